hex_display_scanner: RTL

//   Time-multiplexed controller for a bank of NDIG hex 7-segment digits sharing one segment bus.

---
 rtl/hex_display_scanner.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex 7-segment scanner with frame-aligned commit of loaded values.
// Optional LEADING_ZERO_BLANK_EN: blank digits above the most significant nonzero digit.
module hex_display_scanner #(
  parameter int NDIG  = 4,
  parameter int DWELL = 50000,
  parameter int GAP   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD,
  input  logic [4*NDIG-1:0] BIN,
  output logic [6:0]        SEG,
  output logic [NDIG-1:0]   AN,
  output logic              PEND,
  output logic              FRAME
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int GW = (GAP > 0) ? (($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1) : 1;
  localparam logic [IW-1:0] ILAST = IW'(NDIG - 1);
  localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [GW-1:0]       gcnt_q, gcnt_d;
  logic [4*NDIG-1:0]   pending_q, pending_d;
  logic [4*NDIG-1:0]   active_q, active_d;
  logic                pend_q, pend_d;
  logic [6:0]          seg_q, seg_d;
  logic [NDIG-1:0]     an_q, an_d;
  logic                frame;
  logic [3:0]          nib;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dcnt_d    = dcnt_q;
    gcnt_d    = gcnt_q;
    pending_d = pending_q;
    active_d  = active_q;
    pend_d    = pend_q;
    seg_d     = '0;
    an_d      = '0;
    nib       = '0;
    frame     = (state_q == SHOW) && (idx_q == ILAST) && (dcnt_q == DLAST);

    case (state_q)
      BLANK: begin
        if (GAP == 0 || gcnt_q == GLAST) begin
          state_d = SHOW;
          gcnt_d  = '0;
          dcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: begin
        if (dcnt_q == DLAST) begin
          dcnt_d  = '0;
          idx_d   = (idx_q == ILAST) ? '0 : idx_q + 1'b1;
          state_d = (GAP == 0) ? SHOW : BLANK;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    endcase

    // Commit reads the old pending before a coincident LOAD replaces it.
    if (frame && pend_q) begin
      active_d = pending_q;
      pend_d   = 1'b0;
    end
    if (LOAD) begin
      pending_d = BIN;
      pend_d    = 1'b1;
    end

    // Outputs are derived from next-state values so they change on the entering edge.
    if (state_d == SHOW) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (IW'(i) == idx_d) begin
          an_d[i] = 1'b1;
          nib     = active_d[4*i +: 4];
          seg_d   = glyph(nib);
`ifdef LEADING_ZERO_BLANK_EN
          if (i != 0 && (active_d >> (4*i)) == '0) seg_d = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= BLANK;
      idx_q     <= '0;
      dcnt_q    <= '0;
      gcnt_q    <= '0;
      pending_q <= '0;
      active_q  <= '0;
      pend_q    <= 1'b0;
      seg_q     <= '0;
      an_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dcnt_q    <= dcnt_d;
      gcnt_q    <= gcnt_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign PEND  = pend_q;
  assign FRAME = frame;

endmodule
